// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive controller (8 data bits, LSB first).
//
// Detects the start bit and takes three samples around the centre of each bit.
// A majority vote of those samples gives the bit value. The block deserialises
// the data bits, optionally checks a parity bit, checks the stop bit, and
// reports the frame with one-cycle pulses. It works beside edge_bit_counter:
// this block drives the counter's enable and clear, and uses the counter's
// edge/bit counts as its bit-timing reference.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data when par_en_in is set at frame
//               start (par_typ_in: 0 = even, 1 = odd).
//   undefined : frames are always 10 bits, par_en_in/par_typ_in are ignored
//               and parity_error_out is tied to 0.
//
// Ports:
//   clk              in  RX clock, prescale_in x baud
//   reset_n          in  asynchronous active-low reset
//   rx_in            in  serial line, synchronised, idle high
//   prescale_in[4:0] in  oversampling ratio (8 or 16)
//   par_en_in        in  parity bit present (latched at frame start)
//   par_typ_in       in  0 = even, 1 = odd (latched at frame start)
//   bit_cnt_in[3:0]  in  edge_bit_counter.bit_cnt_out
//   edge_cnt_in[4:0] in  edge_bit_counter.edge_cnt_out
//   en_counter_out   out counter enable (high while a frame is in progress)
//   cnt_clr_out      out one-cycle counter clear at every frame end
//   p_data_out[7:0]  out data of the last good frame
//   data_valid_out   out one-cycle pulse, good frame
//   parity_error_out out one-cycle pulse, parity mismatch
//   stop_error_out   out one-cycle pulse, stop bit sampled low
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic [4:0] prescale_in,
  input  logic       par_en_in,
  input  logic       par_typ_in,
  input  logic [3:0] bit_cnt_in,
  input  logic [4:0] edge_cnt_in,
  output logic       en_counter_out,
  output logic       cnt_clr_out,
  output logic [7:0] p_data_out,
  output logic       data_valid_out,
  output logic       parity_error_out,
  output logic       stop_error_out
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic       s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] p_data_q, p_data_d;
  logic       valid_q, valid_d;
  logic       clr_q, clr_d;
  logic       serr_q, serr_d;

  logic [4:0] half;
  logic [4:0] last_edge;
  logic       bend;
  logic       maj;

  assign half      = prescale_in >> 1;
  assign last_edge = prescale_in - 5'd1;

  assign en_counter_out = (state_q != IDLE);
  assign bend           = en_counter_out && (edge_cnt_in == last_edge);
  assign maj            = (s0_q & s1_q) | (s1_q & s2_q) | (s0_q & s2_q);

  // Three samples around the bit centre. They are taken only while the counter
  // runs, so IDLE (edge count parked at 0) cannot disturb them.
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (en_counter_out) begin
      if (edge_cnt_in == half - 5'd1) s0_d = rx_in;
      if (edge_cnt_in == half)        s1_d = rx_in;
      if (edge_cnt_in == half + 5'd1) s2_d = rx_in;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic perr_q, perr_d;
  logic perr_out_q, perr_out_d;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = par_en_in ^ par_typ_in;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    p_data_d = p_data_q;
    valid_d  = 1'b0;
    clr_d    = 1'b0;
    serr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    perr_d     = perr_q;
    perr_out_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d = START;
`ifdef UART_RX_PARITY_EN
          // Parity settings are frozen for the whole frame.
          par_en_d  = par_en_in;
          par_typ_d = par_typ_in;
          perr_d    = 1'b0;
`endif
        end
      end
      START: begin
        if (bend) begin
          if (maj) begin
            // The line went back high before the bit centre, so this was a glitch.
            state_d = IDLE;
            clr_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bend) begin
          sr_d = {maj, sr_q[7:1]};
          if (bit_cnt_in == 4'd8) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bend) begin
          perr_d  = (maj != (par_typ_q ? ~^sr_q : ^sr_q));
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bend) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          // A stop error outranks a parity error, and either error blocks the data.
          if (!maj) begin
            serr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (perr_q) begin
            perr_out_d = 1'b1;
`endif
          end else begin
            valid_d  = 1'b1;
            p_data_d = sr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sr_q     <= '0;
      p_data_q <= '0;
      valid_q  <= 1'b0;
      clr_q    <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sr_q     <= sr_d;
      p_data_q <= p_data_d;
      valid_q  <= valid_d;
      clr_q    <= clr_d;
      serr_q   <= serr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
    end
  end
  assign parity_error_out = perr_out_q;
`else
  assign parity_error_out = 1'b0;
`endif

  assign cnt_clr_out    = clr_q;
  assign p_data_out     = p_data_q;
  assign data_valid_out = valid_q;
  assign stop_error_out = serr_q;

endmodule
